// File: rtl/mult_share_sched_pkg.sv
// Shared definitions for the add-shift multiplier scheduler.
package mult_share_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned NREQ = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_share_sched_add_shift_core.sv
// Sequential add-shift multiplier datapath: one partial-product step per clock.
module add_shift_core
  import mult_share_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  output logic [2*WIDTH-1:0] o_prod_next,
  output logic               o_last
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [2*WIDTH:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_acc_next;

  // Upper half is WIDTH+1 bits so the carry out of the add survives the shift.
  always_comb begin
    w_sum      = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_next = {w_sum, r_acc[WIDTH-1:0]} >> 1;
  end

  assign o_prod_next = w_acc_next[2*WIDTH-1:0];
  assign o_last      = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_x;
      r_acc   <= {{(WIDTH+1){1'b0}}, i_y};
      r_cnt   <= CW'(WIDTH);
    end else if (i_step) begin
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one add-shift multiplier between two requesters.
module mult_share_sched
  import mult_share_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   y1,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic               out_valid,
  output logic               out_id,
  output logic [2*WIDTH-1:0] p
);

  state_t             r_state;
  logic               r_prio;
  logic               r_id;
  logic [NREQ-1:0]    r_ack;
  logic               r_busy;
  logic               r_out_valid;
  logic               r_out_id;
  logic [2*WIDTH-1:0] r_p;

  logic               w_winner;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic [2*WIDTH-1:0] w_prod_next;

  always_comb begin
    w_winner = (req == 2'b11) ? r_prio : req[1];
    w_x      = w_winner ? x1 : x0;
    w_y      = w_winner ? y1 : y0;
    w_load   = (r_state == ST_IDLE) && (req != '0);
    w_step   = (r_state == ST_RUN);
  end

  add_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_x         (w_x),
    .i_y         (w_y),
    .o_prod_next (w_prod_next),
    .o_last      (w_last)
  );

  // p is taken from the final step's result so it updates on the out_valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_id        <= 1'b0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_id    <= 1'b0;
      r_p         <= '0;
    end else begin
      r_ack       <= '0;
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_ack[w_winner] <= 1'b1;
            r_busy          <= 1'b1;
            r_id            <= w_winner;
            r_prio          <= ~w_winner;
            r_state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_id    <= r_id;
            r_p         <= w_prod_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign p         = r_p;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (WIDTH=4).
module tb_mult_share_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] x0, y0, x1, y1;
  logic [1:0] ack;
  logic       busy;
  logic       out_valid;
  logic       out_id;
  logic [7:0] p;

  int n_checks;
  int n_errors;

  mult_share_sched #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .ack       (ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input string tag);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      step(1);
      if (ack != 2'b00) seen = 1'b1;
      n++;
    end
    if (!seen) check({tag, "_ack_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"},  ack,       16'd0);
    check({tag, "_busy"}, busy,      16'd0);
    check({tag, "_ov"},   out_valid, 16'd0);
    check({tag, "_id"},   out_id,    16'd0);
    check({tag, "_p"},    p,         16'd0);
  endtask

  // Issues one job from IDLE and checks the full ack -> out_valid -> IDLE timeline.
  task automatic do_job(input string tag, input logic id, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] ep);
    if (id) begin x1 = x; y1 = y; end
    else    begin x0 = x; y0 = y; end
    req = id ? 2'b10 : 2'b01;
    wait_ack(tag);
    check({tag, "_ack"}, ack, id ? 16'd2 : 16'd1);
    check({tag, "_busy"}, busy, 16'd1);
    req = 2'b00;
    step(3);
    check({tag, "_ov_early"}, out_valid, 16'd0);
    step(1);
    check({tag, "_ov"}, out_valid, 16'd1);
    check({tag, "_p"}, p, {8'd0, ep});
    check({tag, "_id"}, out_id, {15'd0, id});
    step(1);
    check({tag, "_ov_pulse"}, out_valid, 16'd0);
    check({tag, "_busy_end"}, busy, 16'd0);
    check({tag, "_p_hold"}, p, {8'd0, ep});
  endtask

  initial begin
    bit         seen_ov;
    logic [7:0] v;
    logic [7:0] ep;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req = 2'b00;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #3;
    check_zero_outputs("reset");
    step(2);
    rst_n = 1'b1;
    step(1);

    do_job("j13x11", 1'b0, 4'd13, 4'd11, 8'd143);
    do_job("j0x15",  1'b0, 4'd0,  4'd15, 8'd0);
    do_job("j15x15", 1'b1, 4'd15, 4'd15, 8'hE1);
    do_job("j1x1",   1'b0, 4'd1,  4'd1,  8'd1);

    // Fresh reset so the priority pointer starts at requester 0.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    x0 = 4'd3; y0 = 4'd5; x1 = 4'd7; y1 = 4'd9;
    req = 2'b11;
    wait_ack("rr1");
    check("rr1_ack", ack, 16'd1);
    step(1);
    check("rr1_ack_pulse", ack, 16'd0);
    step(3);
    check("rr1_ov", out_valid, 16'd1);
    check("rr1_p", p, 16'd15);
    check("rr1_id", out_id, 16'd0);
    step(2);
    check("rr2_ack", ack, 16'd2);
    step(4);
    check("rr2_ov", out_valid, 16'd1);
    check("rr2_p", p, 16'd63);
    check("rr2_id", out_id, 16'd1);
    step(2);
    check("rr3_ack", ack, 16'd1);
    req = 2'b00;
    step(4);
    check("rr3_p", p, 16'd15);
    check("rr3_id", out_id, 16'd0);
    step(1);

    x0 = 4'd2; y0 = 4'd3;
    req = 2'b01;
    wait_ack("mid");
    check("mid_ack0", ack, 16'd1);
    req = 2'b00;
    step(2);
    x1 = 4'd5; y1 = 4'd6;
    req = 2'b10;
    step(1);
    check("mid_noack_c3", ack, 16'd0);
    step(1);
    check("mid_noack_c4", ack, 16'd0);
    check("mid_ov0", out_valid, 16'd1);
    check("mid_p0", p, 16'd6);
    step(1);
    check("mid_noack_c5", ack, 16'd0);
    step(1);
    check("mid_ack1_c6", ack, 16'd2);
    req = 2'b00;
    step(4);
    check("mid_ov1", out_valid, 16'd1);
    check("mid_p1", p, 16'd30);
    check("mid_id1", out_id, 16'd1);
    step(1);

    x0 = 4'd9; y0 = 4'd9;
    req = 2'b01;
    wait_ack("rst");
    check("rst_ack", ack, 16'd1);
    req = 2'b00;
    step(2);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    step(2);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (out_valid) seen_ov = 1'b1;
    end
    check("rst_no_ov", {15'd0, seen_ov}, 16'd0);
    do_job("post_rst", 1'b1, 4'd6, 4'd7, 8'd42);

    for (int i = 0; i < 256; i++) begin
      v  = i[7:0];
      ep = {4'd0, v[7:4]} * {4'd0, v[3:0]};
      do_job("sweep", v[0], v[7:4], v[3:0], ep);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
